// File: rtl/mo_tape_pkg.sv
// Shared state type, PCM byte codes and RIFF/WAVE header template for the cassette recorder.
package mo_tape_pkg;

    typedef enum logic [1:0] {StIdle, StRec, StUpl} tape_state_e;

    localparam logic [7:0] PCM_HI  = 8'hC0;
    localparam logic [7:0] PCM_LO  = 8'h40;
    localparam logic [7:0] PCM_SIL = 8'h80;

    localparam int unsigned WAV_HDR_LEN = 44;

    // Size and rate fields are zero here; wav_hdr_byte ORs them in.
    localparam logic [7:0] WAV_HDR_ROM [WAV_HDR_LEN] = '{
        8'h52, 8'h49, 8'h46, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h57, 8'h41, 8'h56, 8'h45, 8'h66, 8'h6D, 8'h74, 8'h20,
        8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h01, 8'h00, 8'h08, 8'h00, 8'h64, 8'h61, 8'h74, 8'h61,
        8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] wav_hdr_byte(input logic [5:0]  idx,
                                                 input logic [31:0] data_len,
                                                 input logic [31:0] rate);
        logic [31:0] field;
        field = 32'd0;
        if (idx >= 6'd4 && idx <= 6'd7) begin
            field = data_len + 32'd36;
        end else if (idx >= 6'd24 && idx <= 6'd31) begin
            // Mono 8-bit: byte rate equals sample rate.
            field = rate;
        end else if (idx >= 6'd40) begin
            field = data_len;
        end
        return WAV_HDR_ROM[idx] | field[8*idx[1:0] +: 8];
    endfunction

endpackage

// File: rtl/mo_tape_fifo.sv
// Single-clock byte FIFO with show-ahead output and synchronous flush.
module mo_tape_fifo #(
    parameter int unsigned AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = cnt_q[AW];
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign dout    = mem[rptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mo_tape_rec.sv
// Cassette recorder: samples k7_out into 8-bit PCM, buffers it and serves it over ioctl upload.
// Define MO_TAPE_WAVHDR_EN to prefix each upload with a 44-byte RIFF/WAVE header.
module mo_tape_rec
    import mo_tape_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_HZ = 44_100,
    parameter int unsigned FIFO_AW   = 14
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic        rec_ena,
    input  logic        k7_out,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic [31:0] rec_count,
    output logic        overflow,
    output logic        underrun
);
    localparam logic [31:0] DIV_LAST = 32'(CLK_HZ / SAMPLE_HZ - 1);

    tape_state_e      state_q;
    logic [31:0]      div_q, count_q;
    logic             rec_ena_q, upload_q, ovf_q, und_q;
    logic [7:0]       din_q, rd_byte, fifo_dout;
    logic             tick, up_rise, up_fall, flush, rd_ok, push, pop, ovf_set, und_set;
    logic             fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_level;
    logic             unused_bits;

`ifdef MO_TAPE_WAVHDR_EN
    logic [31:0]      rd_idx_q;
    logic [FIFO_AW:0] n_q;
    assign unused_bits = ^ioctl_addr;
`else
    assign unused_bits = ^{ioctl_addr, fifo_level};
`endif

    assign tick    = rec_ena && (div_q == DIV_LAST);
    assign up_rise = ioctl_upload && !upload_q;
    assign up_fall = !ioctl_upload && upload_q;
    assign flush   = rec_ena && !rec_ena_q && (state_q == StIdle);
    assign rd_ok   = ioctl_rd && (state_q == StUpl);
    assign push    = tick && !flush;
    assign ovf_set = tick && fifo_full && !pop;

    always_comb begin
        pop     = 1'b0;
        und_set = 1'b0;
        rd_byte = PCM_SIL;
`ifdef MO_TAPE_WAVHDR_EN
        if (rd_ok) begin
            if (rd_idx_q < 32'(WAV_HDR_LEN)) begin
                rd_byte = wav_hdr_byte(rd_idx_q[5:0], 32'(n_q), 32'(SAMPLE_HZ));
            end else if (rd_idx_q < 32'(WAV_HDR_LEN) + 32'(n_q)) begin
                pop     = !fifo_empty;
                und_set = fifo_empty;
                rd_byte = fifo_empty ? PCM_SIL : fifo_dout;
            end
        end
`else
        if (rd_ok) begin
            pop     = !fifo_empty;
            und_set = fifo_empty;
            rd_byte = fifo_empty ? PCM_SIL : fifo_dout;
        end
`endif
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            count_q   <= '0;
            rec_ena_q <= 1'b0;
            upload_q  <= 1'b0;
            ovf_q     <= 1'b0;
            und_q     <= 1'b0;
            din_q     <= PCM_SIL;
        end else begin
            rec_ena_q <= rec_ena;
            upload_q  <= ioctl_upload;
            div_q     <= (!rec_ena || tick) ? '0 : div_q + 32'd1;

            if (up_rise) begin
                state_q <= StUpl;
            end else begin
                unique case (state_q)
                    StIdle:  if (rec_ena) state_q <= StRec;
                    StRec:   if (!rec_ena) state_q <= StIdle;
                    StUpl:   if (up_fall) state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end

            if (flush) begin
                count_q <= '0;
            end else if (tick && count_q != '1) begin
                count_q <= count_q + 32'd1;
            end

            // Clear first so an event in the same cycle still registers.
            if (up_rise) begin
                ovf_q <= 1'b0;
                und_q <= 1'b0;
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (und_set) und_q <= 1'b1;

            if (rd_ok) din_q <= rd_byte;
        end
    end

`ifdef MO_TAPE_WAVHDR_EN
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx_q <= '0;
            n_q      <= '0;
        end else if (up_rise) begin
            rd_idx_q <= '0;
            n_q      <= fifo_level;
        end else if (rd_ok) begin
            rd_idx_q <= rd_idx_q + 32'd1;
        end
    end
`endif

    mo_tape_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (sysclk),
        .rst_n (reset_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (k7_out ? PCM_HI : PCM_LO),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign ioctl_din = din_q;
    assign rec_count = count_q;
    assign overflow  = ovf_q;
    assign underrun  = und_q;

endmodule

// File: tb/tb_mo_tape_rec.sv
// Bench for mo_tape_rec: table scenarios, hand-written corner sequences, random run vs. a model.
`timescale 1ns/1ps
module tb_mo_tape_rec;
    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned SAMPLE_HZ = 100;
    localparam int unsigned FIFO_AW   = 2;
    localparam int          DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int          DEPTH     = 1 << FIFO_AW;
`ifdef MO_TAPE_WAVHDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic        sysclk = 1'b0;
    logic        reset_n, rec_ena, k7_out, ioctl_upload, ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic [31:0] rec_count;
    logic        overflow, underrun;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 sysclk = ~sysclk;

    mo_tape_rec #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .FIFO_AW   (FIFO_AW)
    ) dut (
        .sysclk       (sysclk),
        .reset_n      (reset_n),
        .rec_ena      (rec_ena),
        .k7_out       (k7_out),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .rec_count    (rec_count),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    // Reference model state
    logic [7:0]  m_q[$];
    logic [7:0]  m_din;
    logic [31:0] m_cnt;
    bit          m_ovf, m_und, m_sess, m_prev_rec, m_prev_up;
    int          m_run;
    int unsigned m_ridx, m_n;

    function automatic logic [7:0] wav_ref(int unsigned i, int unsigned n);
        logic [31:0] w [11];
        w[0]  = 32'h4646_4952;
        w[1]  = n + 36;
        w[2]  = 32'h4556_4157;
        w[3]  = 32'h2074_6D66;
        w[4]  = 32'd16;
        w[5]  = 32'h0001_0001;
        w[6]  = SAMPLE_HZ;
        w[7]  = SAMPLE_HZ * 1 * 8 / 8;
        w[8]  = 32'h0008_0001;
        w[9]  = 32'h6174_6164;
        w[10] = n;
        return 8'(w[i / 4] >> (8 * (i % 4)));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_din = 8'h80; m_cnt = 0; m_ovf = 0; m_und = 0; m_sess = 0;
        m_prev_rec = 0; m_prev_up = 0; m_run = 0; m_ridx = 0; m_n = 0;
    endtask

    task automatic model_step();
        bit tick, flush, rd, up_rise, up_fall;
        tick    = rec_ena && ((m_run + 1) % DIV == 0);
        flush   = rec_ena && !m_prev_rec && !m_sess;
        up_rise = ioctl_upload && !m_prev_up;
        up_fall = !ioctl_upload && m_prev_up;
        rd      = ioctl_rd && m_sess;
        if (rd) begin
            if (HDR && m_ridx < 44) begin
                m_din = wav_ref(m_ridx, m_n);
            end else if (!HDR || m_ridx < 44 + m_n) begin
                if (m_q.size() > 0) m_din = m_q.pop_front();
                else begin m_din = 8'h80; m_und = 1; end
            end else begin
                m_din = 8'h80;
            end
            m_ridx++;
        end
        if (up_rise) begin
            m_n = m_q.size(); m_ridx = 0; m_ovf = 0; m_und = 0;
        end
        if (flush) begin
            m_q.delete(); m_cnt = 0;
        end
        if (tick) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (m_q.size() < DEPTH) m_q.push_back(k7_out ? 8'hC0 : 8'h40);
            else m_ovf = 1;
        end
        if (up_rise) m_sess = 1;
        else if (up_fall) m_sess = 0;
        m_run      = rec_ena ? m_run + 1 : 0;
        m_prev_rec = rec_ena;
        m_prev_up  = ioctl_upload;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge sysclk);
        model_step();
        #1;
        chk("model_din", 32'(ioctl_din), 32'(m_din));
        chk("model_count", rec_count, m_cnt);
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
        chk("model_underrun", 32'(underrun), 32'(m_und));
    endtask

    task automatic do_reset();
        reset_n = 0; rec_ena = 0; k7_out = 0; ioctl_upload = 0; ioctl_rd = 0; ioctl_addr = '0;
        model_reset();
        repeat (2) @(posedge sysclk);
        #1;
        chk("reset_din", 32'(ioctl_din), 32'h80);
        chk("reset_count", rec_count, 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        @(negedge sysclk);
        reset_n = 1;
    endtask

    task automatic read_pulse();
        ioctl_rd = 1; cycle();
        ioctl_rd = 0;
    endtask

    typedef struct {
        int          rec_cycles;
        logic [15:0] pat;
        logic [31:0] count;
        bit          ovf;
        bit          und;
        logic [31:0] rd_bytes;
    } vec_t;

    initial begin
        vec_t tbl[5];
        logic [7:0] got [48];
        tbl[0] = '{100, 16'hFFFF, 32'd10, 1'b1, 1'b0, 32'hC0C0_C0C0};
        tbl[1] = '{40,  16'h0005, 32'd4,  1'b0, 1'b0, 32'h40C0_40C0};
        tbl[2] = '{60,  16'h0035, 32'd6,  1'b1, 1'b0, 32'h40C0_40C0};
        tbl[3] = '{0,   16'h0000, 32'd0,  1'b0, 1'b1, 32'h8080_8080};
        tbl[4] = '{30,  16'h0002, 32'd3,  1'b0, 1'b1, 32'h8040_C040};

        for (int t = 0; t < 5; t++) begin
            do_reset();
            rec_ena = 1;
            for (int i = 0; i < tbl[t].rec_cycles; i++) begin
                k7_out = tbl[t].pat[i / DIV];
                cycle();
            end
            rec_ena = 0; k7_out = 0;
            cycle();
            chk($sformatf("tbl%0d_count", t), rec_count, tbl[t].count);
            chk($sformatf("tbl%0d_overflow", t), 32'(overflow), 32'(tbl[t].ovf));
            ioctl_upload = 1; cycle(); cycle();
`ifdef MO_TAPE_WAVHDR_EN
            for (int h = 0; h < 44; h++) begin read_pulse(); cycle(); end
`endif
            for (int r = 0; r < 4; r++) begin
                read_pulse();
                chk($sformatf("tbl%0d_din%0d", t, r), 32'(ioctl_din),
                    32'(tbl[t].rd_bytes[8*r +: 8]));
                cycle();
            end
            chk($sformatf("tbl%0d_underrun", t), 32'(underrun),
                32'(HDR ? 1'b0 : tbl[t].und));
            ioctl_upload = 0; cycle(); cycle();
            // A fresh session clears the sticky flags.
            ioctl_upload = 1; cycle();
            chk($sformatf("tbl%0d_und_clear", t), 32'(underrun), 32'd0);
            chk($sformatf("tbl%0d_ovf_clear", t), 32'(overflow), 32'd0);
            ioctl_upload = 0; cycle();
        end

        // Read outside a session is ignored; ioctl_din holds.
        do_reset();
        rec_ena = 1; k7_out = 1;
        repeat (10) cycle();
        rec_ena = 0; cycle();
        read_pulse();
        chk("rd_outside_din", 32'(ioctl_din), 32'h80);
        ioctl_upload = 1; cycle(); cycle();
        read_pulse();
        chk("rd_first_sample", 32'(ioctl_din), HDR ? 32'h52 : 32'hC0);
        repeat (3) cycle();
        chk("din_hold", 32'(ioctl_din), HDR ? 32'h52 : 32'hC0);

        // Reset asserted mid-upload.
        do_reset();
        rec_ena = 1; k7_out = 1;
        repeat (30) cycle();
        rec_ena = 0; cycle();
        ioctl_upload = 1; cycle(); cycle();
        read_pulse();
        #2 reset_n = 0;
        model_reset();
        @(posedge sysclk); #1;
        chk("midrst_din", 32'(ioctl_din), 32'h80);
        chk("midrst_count", rec_count, 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        @(negedge sysclk);
        reset_n = 1;
        cycle(); cycle();
`ifndef MO_TAPE_WAVHDR_EN
        read_pulse();
        chk("midrst_empty_din", 32'(ioctl_din), 32'h80);
        chk("midrst_empty_und", 32'(underrun), 32'd1);
`endif
        ioctl_upload = 0; cycle();

`ifdef MO_TAPE_WAVHDR_EN
        begin
            int          idx [12] = '{0, 1, 2, 3, 24, 40, 41, 42, 43, 44, 45, 46};
            logic [7:0]  val [12] = '{8'h52, 8'h49, 8'h46, 8'h46, 8'h64, 8'h03, 8'h00,
                                      8'h00, 8'h00, 8'hC0, 8'h40, 8'hC0};
            do_reset();
            rec_ena = 1;
            for (int i = 0; i < 30; i++) begin
                k7_out = ((i / DIV) != 1);
                cycle();
            end
            rec_ena = 0; cycle();
            ioctl_upload = 1; cycle(); cycle();
            for (int r = 0; r < 48; r++) begin
                read_pulse();
                got[r] = ioctl_din;
                cycle();
            end
            for (int k = 0; k < 12; k++) begin
                chk($sformatf("hdr_byte%0d", idx[k]), 32'(got[idx[k]]), 32'(val[k]));
            end
            chk("hdr_tail", 32'(got[47]), 32'h80);
            chk("hdr_no_und", 32'(underrun), 32'd0);
            ioctl_upload = 0; cycle();
        end
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) rec_ena = !rec_ena;
            if ($urandom_range(0, 79) == 0) ioctl_upload = !ioctl_upload;
            k7_out     = 1'($urandom_range(0, 1));
            ioctl_rd   = ($urandom_range(0, 3) == 0);
            ioctl_addr = 25'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
